dmi_byte_initiator: RTL and testbench

- Debug transport front-end: turns framed requests arriving on a byte stream (UART RX or host FIFO) into single DMI transactions, and returns framed responses on an outbound byte stream.
- It is the initiator of the DMI trivial bus. It drives `dmi_start`, `dmi_op`, `dmi_address` and `dmi_data_o` into the DM, and collects `dmi_data_i` when `dmi_finish` is seen.
- It sits in the same clock domain as the DM, so no synchronisers are needed.

---
 rtl/dmi_byte_initiator.sv | 207 ++++++++++++++++++++
 tb/tb_dmi_byte_initiator.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmi_byte_initiator.sv
// Byte-stream debug transport front-end: collects 6-byte request frames, issues one DMI
// transaction per frame and returns a 5-byte response frame.
// Optional feature macro: DMI_FINISH_TIMEOUT_EN (bounds the wait for dmi_finish and
// answers status 0x02 with data 0xFFFFFFFF when it expires).
module dmi_byte_initiator #(
  parameter int unsigned RX_TIMEOUT_CYCLES     = 65535,
  parameter int unsigned FINISH_TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        dmi_start,
  input  logic        dmi_finish,
  output logic [1:0]  dmi_op,
  output logic [6:0]  dmi_address,
  output logic [31:0] dmi_data_o,
  input  logic [31:0] dmi_data_i
);

  localparam int unsigned RxCntW = $clog2(RX_TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    StRxCmd,
    StRxAddr,
    StRxData,
    StDecode,
    StIssue,
    StWait,
    StTxStatus,
    StTxData
  } state_t;

  state_t             r_state;
  logic [7:0]         r_cmd;
  logic [6:0]         r_addr;
  logic [31:0]        r_wdata;
  logic [31:0]        r_resp;
  logic [1:0]         r_byte_cnt;
  logic [RxCntW-1:0]  r_rx_cnt;
  logic               r_dmi_start;
  logic [1:0]         r_dmi_op;
  logic [6:0]         r_dmi_address;
  logic [31:0]        r_dmi_data_o;
  logic               r_tx_valid;
  logic [7:0]         r_tx_data;

  logic w_rx_ready;
  logic w_rx_fire;
  logic w_tx_fire;
  logic w_rx_expire;
  logic w_cmd_valid;

`ifdef DMI_FINISH_TIMEOUT_EN
  localparam int unsigned FinCntW = $clog2(FINISH_TIMEOUT_CYCLES + 1);
  logic [FinCntW-1:0] r_fin_cnt;
  logic               w_fin_expire;
  assign w_fin_expire = (r_fin_cnt == FinCntW'(FINISH_TIMEOUT_CYCLES - 1));
`else
  logic w_unused_fin;
  assign w_unused_fin = ^FINISH_TIMEOUT_CYCLES;
`endif

  // Handshake and decode helpers derived from the registered state.
  always_comb begin
    w_rx_ready  = (r_state == StRxCmd) || (r_state == StRxAddr) || (r_state == StRxData);
    w_rx_fire   = w_rx_ready && rx_valid;
    w_tx_fire   = r_tx_valid && tx_ready;
    // Idle cycle that would bring the inter-byte counter up to the limit.
    w_rx_expire = (r_rx_cnt == RxCntW'(RX_TIMEOUT_CYCLES - 1));
    w_cmd_valid = (r_cmd[7:2] == 6'd0) && ((r_cmd[1:0] == 2'd1) || (r_cmd[1:0] == 2'd2));
  end

  // Frame receive, DMI issue and response transmit sequencing with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= StRxCmd;
      r_cmd         <= 8'd0;
      r_addr        <= 7'd0;
      r_wdata       <= 32'd0;
      r_resp        <= 32'd0;
      r_byte_cnt    <= 2'd0;
      r_rx_cnt      <= '0;
      r_dmi_start   <= 1'b0;
      r_dmi_op      <= 2'd0;
      r_dmi_address <= 7'd0;
      r_dmi_data_o  <= 32'd0;
      r_tx_valid    <= 1'b0;
      r_tx_data     <= 8'd0;
`ifdef DMI_FINISH_TIMEOUT_EN
      r_fin_cnt     <= '0;
`endif
    end else begin
      r_dmi_start <= 1'b0;
      unique case (r_state)
        StRxCmd: begin
          r_rx_cnt <= '0;
          if (w_rx_fire) begin
            r_cmd   <= rx_data;
            r_state <= StRxAddr;
          end
        end
        StRxAddr: begin
          if (w_rx_fire) begin
            r_addr     <= rx_data[6:0];
            r_byte_cnt <= 2'd0;
            r_rx_cnt   <= '0;
            r_state    <= StRxData;
          end else if (w_rx_expire) begin
            r_rx_cnt <= '0;
            r_state  <= StRxCmd;
          end else begin
            r_rx_cnt <= r_rx_cnt + RxCntW'(1);
          end
        end
        StRxData: begin
          if (w_rx_fire) begin
            // Shift in from the top so the first data byte ends up least significant.
            r_wdata    <= {rx_data, r_wdata[31:8]};
            r_byte_cnt <= r_byte_cnt + 2'd1;
            r_rx_cnt   <= '0;
            if (r_byte_cnt == 2'd3) begin
              r_state <= StDecode;
            end
          end else if (w_rx_expire) begin
            r_rx_cnt <= '0;
            r_state  <= StRxCmd;
          end else begin
            r_rx_cnt <= r_rx_cnt + RxCntW'(1);
          end
        end
        StDecode: begin
          r_dmi_op      <= r_cmd[1:0];
          r_dmi_address <= r_addr;
          r_dmi_data_o  <= r_wdata;
          if (w_cmd_valid) begin
            r_dmi_start <= 1'b1;
            r_state     <= StIssue;
          end else begin
            // Nop answers OK, anything else malformed answers bad command; no DMI access.
            r_resp     <= 32'd0;
            r_tx_data  <= (r_cmd == 8'd0) ? 8'h00 : 8'h01;
            r_tx_valid <= 1'b1;
            r_state    <= StTxStatus;
          end
        end
        StIssue: begin
`ifdef DMI_FINISH_TIMEOUT_EN
          r_fin_cnt <= '0;
`endif
          r_state <= StWait;
        end
        StWait: begin
          if (dmi_finish) begin
            r_resp     <= dmi_data_i;
            r_tx_data  <= 8'h00;
            r_tx_valid <= 1'b1;
            r_state    <= StTxStatus;
`ifdef DMI_FINISH_TIMEOUT_EN
          end else if (w_fin_expire) begin
            r_resp     <= 32'hFFFF_FFFF;
            r_tx_data  <= 8'h02;
            r_tx_valid <= 1'b1;
            r_state    <= StTxStatus;
          end else begin
            r_fin_cnt <= r_fin_cnt + FinCntW'(1);
`endif
          end
        end
        StTxStatus: begin
          if (w_tx_fire) begin
            r_tx_data  <= r_resp[7:0];
            r_resp     <= {8'd0, r_resp[31:8]};
            r_byte_cnt <= 2'd0;
            r_state    <= StTxData;
          end
        end
        StTxData: begin
          if (w_tx_fire) begin
            if (r_byte_cnt == 2'd3) begin
              r_tx_valid <= 1'b0;
              r_state    <= StRxCmd;
            end else begin
              r_tx_data  <= r_resp[7:0];
              r_resp     <= {8'd0, r_resp[31:8]};
              r_byte_cnt <= r_byte_cnt + 2'd1;
            end
          end
        end
        default: r_state <= StRxCmd;
      endcase
    end
  end

  assign rx_ready    = w_rx_ready;
  assign tx_data     = r_tx_data;
  assign tx_valid    = r_tx_valid;
  assign dmi_start   = r_dmi_start;
  assign dmi_op      = r_dmi_op;
  assign dmi_address = r_dmi_address;
  assign dmi_data_o  = r_dmi_data_o;

endmodule

// File: tb/tb_dmi_byte_initiator.sv
// Self-checking bench for dmi_byte_initiator: directed vector table, hand-written corner
// sequences and randomized frames checked against a frame-level reference model.
module tb_dmi_byte_initiator;

  localparam int unsigned RxTo  = 16;
  localparam int unsigned FinTo = 8;
`ifdef DMI_FINISH_TIMEOUT_EN
  localparam bit FinEn = 1'b1;
`else
  localparam bit FinEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        dmi_start;
  logic        dmi_finish;
  logic [1:0]  dmi_op;
  logic [6:0]  dmi_address;
  logic [31:0] dmi_data_o;
  logic [31:0] dmi_data_i;

  dmi_byte_initiator #(
    .RX_TIMEOUT_CYCLES    (RxTo),
    .FINISH_TIMEOUT_CYCLES(FinTo)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .dmi_start  (dmi_start),
    .dmi_finish (dmi_finish),
    .dmi_op     (dmi_op),
    .dmi_address(dmi_address),
    .dmi_data_o (dmi_data_o),
    .dmi_data_i (dmi_data_i)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // DM responder state, set by the main sequence before each frame.
  int          dm_lat   = 2;
  bit          dm_never = 1'b0;
  logic [31:0] dm_rdata = 32'd0;
  logic [1:0]  exp_op;
  logic [6:0]  exp_addr;
  logic [31:0] exp_wdata;
  int          start_cnt = 0;

  // Behavioural DM: answers each start after dm_lat cycles, checks request fields.
  initial begin : dm_model
    dmi_finish = 1'b0;
    dmi_data_i = 32'd0;
    forever begin
      @(negedge clk);
      if (rst_n && dmi_start) begin
        start_cnt++;
        check("dmi_op", 32'(dmi_op), 32'(exp_op));
        check("dmi_address", 32'(dmi_address), 32'(exp_addr));
        check("dmi_data_o", dmi_data_o, exp_wdata);
        @(negedge clk);
        check("dmi_start_one_cycle", 32'(dmi_start), 32'd0);
        if (!dm_never) begin
          repeat (dm_lat - 1) @(negedge clk);
          dmi_finish = 1'b1;
          dmi_data_i = dm_rdata;
          @(negedge clk);
          dmi_finish = 1'b0;
          dmi_data_i = $urandom;
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge following the byte's transfer.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    n = 0;
    while (!rx_ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("rx_ready_wait", 32'(rx_ready), 32'd1);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  // Collects 5 response bytes; holds tx_ready low for 'hold' cycles, then random stalls.
  task automatic recv_resp(input int bp, input int hold, output logic [39:0] r);
    int i;
    int n;
    logic [7:0] held;
    bit stalled;
    i = 0;
    n = 0;
    held = 8'd0;
    stalled = 1'b0;
    r = 40'd0;
    while (i < 5 && n < 5000) begin
      tx_ready = (n < hold) ? 1'b0 : ($urandom_range(99) >= bp);
      if (tx_valid) begin
        if (stalled) check("tx_data_hold", 32'(tx_data), 32'(held));
        check("rx_ready_during_tx", 32'(rx_ready), 32'd0);
        if (tx_ready) begin
          r[8*i +: 8] = tx_data;
          i++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          held = tx_data;
        end
      end
      @(negedge clk);
      n++;
    end
    tx_ready = 1'b0;
    check("tx_byte_count", 32'(i), 32'd5);
  endtask

  // Sends one frame, checks latency, response frame and number of DMI starts.
  task automatic run_frame(input logic [7:0] cmd, input logic [7:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rdata,
                           input int lat, input int gmax, input int fix_idx,
                           input int fix_gap, input int bp, input int hold, input bit never);
    logic [47:0] fr;
    logic [39:0] resp;
    bit          issue;
    bit          timed_out;
    logic [7:0]  est;
    logic [31:0] edat;
    int          s0;
    int          n;
    int          g;
    fr        = {wdata, addr, cmd};
    issue     = (cmd == 8'd1) || (cmd == 8'd2);
    timed_out = issue && (never || (FinEn && lat > int'(FinTo)));
    if (timed_out) begin
      est  = 8'h02;
      edat = 32'hFFFF_FFFF;
    end else if (issue) begin
      est  = 8'h00;
      edat = rdata;
    end else begin
      est  = (cmd == 8'd0) ? 8'h00 : 8'h01;
      edat = 32'd0;
    end
    exp_op    = cmd[1:0];
    exp_addr  = addr[6:0];
    exp_wdata = wdata;
    dm_rdata  = rdata;
    dm_lat    = lat;
    dm_never  = never;
    s0        = start_cnt;
    for (int i = 0; i < 6; i++) begin
      g = (i == fix_idx) ? fix_gap : int'($urandom_range(gmax));
      send_byte(fr[8*i +: 8], g);
    end
    n = 0;
    while (!tx_valid && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!issue)         check("latency_no_dmi", 32'(n), 32'd1);
    else if (timed_out) check("latency_timeout", 32'(n), 32'(FinTo + 2));
    else                check("latency_dmi", 32'(n), 32'(lat + 2));
    recv_resp(bp, hold, resp);
    check("resp_status", 32'(resp[7:0]), 32'(est));
    check("resp_data", resp[39:8], edat);
    check("start_count", 32'(start_cnt - s0), 32'(issue));
    check("idle_tx_valid", 32'(tx_valid), 32'd0);
    check("idle_rx_ready", 32'(rx_ready), 32'd1);
  endtask

  typedef struct {
    logic [7:0]  cmd;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          lat;
    int          bp;
    int          hold;
  } vec_t;

  vec_t tbl[8];

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int s0;
    int r;
    logic [7:0] cmd;

    tbl[0] = '{8'h02, 8'h10, 32'h8000_0001, 32'h1234_5678, 2, 0, 0};
    tbl[1] = '{8'h01, 8'h11, 32'h0000_0000, 32'h0040_0C82, 2, 0, 0};
    tbl[2] = '{8'h03, 8'h10, 32'h0000_0000, 32'hDEAD_BEEF, 2, 0, 0};
    tbl[3] = '{8'h00, 8'h10, 32'h0000_0000, 32'hDEAD_BEEF, 2, 0, 0};
    tbl[4] = '{8'h06, 8'h10, 32'h0000_0000, 32'hDEAD_BEEF, 2, 0, 0};
    tbl[5] = '{8'h05, 8'h7F, 32'h5555_AAAA, 32'hDEAD_BEEF, 2, 0, 0};
    tbl[6] = '{8'h01, 8'hFF, 32'h0000_0000, 32'hA5A5_5A5A, 1, 30, 0};
    tbl[7] = '{8'h02, 8'h25, 32'h0BAD_CAFE, 32'h1122_3344, 6, 0, 50};

    rst_n    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'd0;
    tx_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_dmi_start", 32'(dmi_start), 32'd0);
    check("reset_dmi_op", 32'(dmi_op), 32'd0);
    check("reset_dmi_address", 32'(dmi_address), 32'd0);
    check("reset_dmi_data_o", dmi_data_o, 32'd0);
    check("reset_tx_valid", 32'(tx_valid), 32'd0);
    check("reset_tx_data", 32'(tx_data), 32'd0);
    check("reset_rx_ready", 32'(rx_ready), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      run_frame(tbl[i].cmd, tbl[i].addr, tbl[i].wdata, tbl[i].rdata, tbl[i].lat, 0, -1, 0,
                tbl[i].bp, tbl[i].hold, 1'b0);
    end

    // Long idle before a command byte never times out.
    run_frame(8'h01, 8'h21, 32'd0, 32'h0F0E_0D0C, 3, 0, 0, 40, 0, 0, 1'b0);
    // Byte arriving on the last idle cycle before expiry keeps the frame alive.
    run_frame(8'h02, 8'h33, 32'hCAFE_0001, 32'h7777_8888, 2, 0, 2, RxTo - 1, 0, 0, 1'b0);

    // Partial frame stalled for the full timeout is dropped silently.
    s0 = start_cnt;
    send_byte(8'h01, 0);
    send_byte(8'h11, 0);
    run_frame(8'h01, 8'h22, 32'd0, 32'hCAFE_F00D, 2, 0, 0, RxTo, 0, 0, 1'b0);
    check("drop_start_count", 32'(start_cnt - s0), 32'd1);

    // Finish landing exactly on the last allowed wait cycle wins.
    run_frame(8'h01, 8'h05, 32'd0, 32'h0BEE_F00D, int'(FinTo), 0, -1, 0, 0, 0, 1'b0);
    // Late finish: timeout response when enabled, normal response otherwise.
    run_frame(8'h02, 8'h06, 32'h1357_9BDF, 32'h2468_ACE0, int'(FinTo) + 1, 0, -1, 0, 0, 0,
              1'b0);
`ifdef DMI_FINISH_TIMEOUT_EN
    run_frame(8'h01, 8'h12, 32'd0, 32'h0000_1234, 2, 0, -1, 0, 0, 0, 1'b1);
`endif

    // Reset while waiting for the DM abandons the transaction without a response.
    exp_op    = 2'd1;
    exp_addr  = 7'h44;
    exp_wdata = 32'd0;
    dm_never  = 1'b1;
    s0        = start_cnt;
    send_byte(8'h01, 0);
    send_byte(8'h44, 0);
    for (int i = 0; i < 4; i++) send_byte(8'h00, 0);
    repeat (3) @(negedge clk);
    check("wait_start_count", 32'(start_cnt - s0), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_wait_dmi_start", 32'(dmi_start), 32'd0);
    check("rst_wait_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_wait_rx_ready", 32'(rx_ready), 32'd1);
    @(negedge clk);
    rst_n    = 1'b1;
    dm_never = 1'b0;
    repeat (20) @(negedge clk);
    check("rst_no_response", 32'(tx_valid), 32'd0);
    run_frame(8'h01, 8'h11, 32'd0, 32'h0040_0C82, 2, 0, -1, 0, 0, 0, 1'b0);

    // Randomized frames against the frame-level model.
    for (int k = 0; k < 40; k++) begin
      r = int'($urandom_range(9));
      if (r <= 3)      cmd = 8'h01;
      else if (r <= 6) cmd = 8'h02;
      else if (r == 7) cmd = 8'h00;
      else if (r == 8) cmd = 8'h03;
      else             cmd = 8'($urandom);
      run_frame(cmd, 8'($urandom), $urandom, $urandom, int'($urandom_range(6, 1)), 3, -1, 0,
                int'($urandom_range(60)), 0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
